// File: rtl/array_arb_pkg.sv
// Shared types and constants for the two-requester scratch-array arbiter.
package array_arb_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    typedef logic req_id_t;

    localparam int REQ_COUNT = 2;

endpackage : array_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way combinational pick: round-robin on last_grant, or fixed priority to
// requester 0 when ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import array_arb_pkg::*;
(
    input  logic [REQ_COUNT-1:0] eligible,
    input  logic                 last_grant,
    output logic                 valid,
    output logic                 winner
);

    // NOTE: every output gets a default first so no path through the block
    // can leave a value unassigned and infer a latch.
    always_comb begin
        valid  = |eligible;
        winner = 1'b0;
        if (eligible == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant;
`endif
        end else if (eligible[1]) begin
            winner = 1'b1;
        end
    end

endmodule : rr_arb2

// File: rtl/array_port_arbiter.sv
// Two-port arbiter in front of a DEPTH x WIDTH register array, with a
// post-reset clear sequence. Define ARB_FIXED_PRIO_EN for fixed priority.
module array_port_arbiter
    import array_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  wdata0,
    output logic              ack0,
    output logic [WIDTH-1:0]  rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              ack1,
    output logic [WIDTH-1:0]  rdata1,

    output logic              busy
);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_idx;
    logic [WIDTH-1:0]    mem [DEPTH];

    logic [REQ_COUNT-1:0] eligible;
    logic                 pick_valid;
    logic                 winner;
    logic                 last_grant;
    logic                 grant;
    logic                 g_we;
    logic [ADDR_W-1:0]    g_addr;
    logic [WIDTH-1:0]     g_wdata;

    // A requester that was just acked still holds req this cycle; mask it.
    assign eligible = {req1 & ~ack1, req0 & ~ack0};

    rr_arb2 u_arb (
        .eligible   (eligible),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (winner)
    );

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_idx == ADDR_W'(DEPTH - 1)) begin
            state_next = RUN;
        end
    end

    assign busy    = (state == CLEAR);
    assign grant   = pick_valid && (state == RUN);
    assign g_we    = winner ? we1    : we0;
    assign g_addr  = winner ? addr1  : addr0;
    assign g_wdata = winner ? wdata1 : wdata0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state <= state_next;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
            if (grant) begin
                if (winner) begin
                    ack1   <= 1'b1;
                    rdata1 <= g_we ? '0 : mem[g_addr];
                end else begin
                    ack0   <= 1'b1;
                    rdata0 <= g_we ? '0 : mem[g_addr];
                end
            end
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign last_grant = 1'b0;
`else
    // Reset to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant) begin
            last_grant <= winner;
        end
    end
`endif

    // NOTE: the array itself has no reset; the CLEAR sequence zeroes it, which
    // keeps the storage a plain register file. Writes are blocked during reset
    // so an in-flight access is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (grant && g_we) begin
                mem[g_addr] <= g_wdata;
            end
        end
    end

endmodule : array_port_arbiter

// File: tb/tb_array_port_arbiter.sv
// Self-checking bench for array_port_arbiter: a cycle table plus directed
// sequences for round-robin and mid-operation reset.
module tb_array_port_arbiter;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [WIDTH-1:0]  wdata0, wdata1;
    logic              ack0, ack1, busy;
    logic [WIDTH-1:0]  rdata0, rdata1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    array_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .we0    (we0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .ack0   (ack0),
        .rdata0 (rdata0),
        .req1   (req1),
        .we1    (we1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .ack1   (ack1),
        .rdata1 (rdata1),
        .busy   (busy)
    );

    typedef struct {
        logic              rst;
        logic              r0, w0;
        logic [ADDR_W-1:0] a0;
        logic [WIDTH-1:0]  d0;
        logic              r1, w1;
        logic [ADDR_W-1:0] a1;
        logic [WIDTH-1:0]  d1;
        logic              e_ack0;
        logic [WIDTH-1:0]  e_rd0;
        logic              e_ack1;
        logic [WIDTH-1:0]  e_rd1;
        logic              e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic r0, input logic w0,
                         input logic [ADDR_W-1:0] a0, input logic [WIDTH-1:0] d0,
                         input logic r1, input logic w1,
                         input logic [ADDR_W-1:0] a1, input logic [WIDTH-1:0] d1);
        reset  = rst;
        req0   = r0;  we0 = w0;  addr0 = a0;  wdata0 = d0;
        req1   = r1;  we1 = w1;  addr1 = a1;  wdata1 = d1;
    endtask

    function automatic vec_t mk(input logic rst,
                                input logic r0, input logic w0,
                                input logic [ADDR_W-1:0] a0, input logic [WIDTH-1:0] d0,
                                input logic r1, input logic w1,
                                input logic [ADDR_W-1:0] a1, input logic [WIDTH-1:0] d1,
                                input logic ea0, input logic [WIDTH-1:0] er0,
                                input logic ea1, input logic [WIDTH-1:0] er1,
                                input logic eb);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.e_ack0 = ea0; v.e_rd0 = er0; v.e_ack1 = ea1; v.e_rd1 = er1;
        v.e_busy = eb;
        return v;
    endfunction

    initial begin
        logic [WIDTH-1:0] d11, dbe;
        bit               seen;
        d11 = 32'h1111_1111;
        dbe = 32'hDEAD_BEEF;

        // Reset, clear (busy for exactly 4 cycles), reads of 0..3 from port 0.
        vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1,0,0,0, 0,0,0,0, 0,0, 0,0, (i < 3)));
        vecs.push_back(mk(0, 1,0,0,0, 0,0,0,0, 1,0, 0,0, 0));
        for (int a = 1; a < 4; a++) begin
            vecs.push_back(mk(0, 1,0,2'(a),0, 0,0,0,0, 0,0, 0,0, 0));
            vecs.push_back(mk(0, 1,0,2'(a),0, 0,0,0,0, 1,0, 0,0, 0));
        end
        // Write 0x11111111 to addr 2 then read it back; rdata0 holds afterwards.
        vecs.push_back(mk(0, 1,1,2,d11, 0,0,0,0, 0,0,   0,0, 0));
        vecs.push_back(mk(0, 1,1,2,d11, 0,0,0,0, 1,0,   0,0, 0));
        vecs.push_back(mk(0, 1,0,2,0,   0,0,0,0, 0,0,   0,0, 0));
        vecs.push_back(mk(0, 1,0,2,0,   0,0,0,0, 1,d11, 0,0, 0));
        vecs.push_back(mk(0, 0,0,0,0,   0,0,0,0, 0,d11, 0,0, 0));
        // Conflict after a port-0 grant: port 1 write to addr 3 vs port 0 read.
        if (!FIXED) begin
            vecs.push_back(mk(0, 1,0,3,0, 1,1,3,dbe, 0,d11, 1,0,   0));
            vecs.push_back(mk(0, 1,0,3,0, 1,1,3,dbe, 1,dbe, 0,0,   0));
            vecs.push_back(mk(0, 0,0,0,0, 1,0,3,0,   0,dbe, 1,dbe, 0));
            vecs.push_back(mk(0, 0,0,0,0, 1,0,3,0,   0,dbe, 0,dbe, 0));
        end else begin
            vecs.push_back(mk(0, 1,0,3,0, 1,1,3,dbe, 1,0, 0,0,   0));
            vecs.push_back(mk(0, 1,0,3,0, 1,1,3,dbe, 0,0, 1,0,   0));
            vecs.push_back(mk(0, 0,0,0,0, 1,0,3,0,   0,0, 0,0,   0));
            vecs.push_back(mk(0, 0,0,0,0, 1,0,3,0,   0,0, 1,dbe, 0));
        end

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            step();
            check($sformatf("vec%0d ack0", i),   WIDTH'(ack0), WIDTH'(vecs[i].e_ack0));
            check($sformatf("vec%0d rdata0", i), rdata0,       vecs[i].e_rd0);
            check($sformatf("vec%0d ack1", i),   WIDTH'(ack1), WIDTH'(vecs[i].e_ack1));
            check($sformatf("vec%0d rdata1", i), rdata1,       vecs[i].e_rd1);
            check($sformatf("vec%0d busy", i),   WIDTH'(busy), WIDTH'(vecs[i].e_busy));
        end

        // Both ports held from the first RUN cycle: grants alternate 0,1,0,1.
        drive(1, 0,0,0,0, 0,0,0,0);
        step();
        drive(0, 1,0,1,0, 1,0,3,0);
        for (int i = 0; i < 4; i++) step();
        check("rr busy after clear", WIDTH'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr ack0 c%0d", i), WIDTH'(ack0), WIDTH'(i % 2 == 0));
            check($sformatf("rr ack1 c%0d", i), WIDTH'(ack1), WIDTH'(i % 2 == 1));
        end

        // Mid-operation reset: a completed write, then reset in place of a grant.
        drive(0, 0,0,0,0, 0,0,0,0);
        step();
        step();
        drive(0, 1,1,1,32'h1234_5678, 0,0,0,0);
        step();
        check("pre-reset write ack0", WIDTH'(ack0), 1);
        drive(1, 1,1,2,32'hCAFE_F00D, 0,0,0,0);
        step();
        check("reset ack0 dropped", WIDTH'(ack0), 0);
        check("reset busy",         WIDTH'(busy), 1);
        check("reset rdata0",       rdata0,       0);
        drive(0, 0,0,0,0, 0,0,0,0);
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0,0,0,0, 1,0,2'(a),0);
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                step();
                if (ack1) seen = 1'b1;
            end
            check($sformatf("post-reset ack1 a%0d seen", a), WIDTH'(seen), 1);
            check($sformatf("post-reset rdata1 a%0d", a), rdata1, 0);
        end
        drive(0, 0,0,0,0, 0,0,0,0);
        step();

`ifdef ARB_FIXED_PRIO_EN
        // Port 0 held continuously wins every conflict; release lets port 1 in.
        drive(0, 1,0,0,0, 0,0,0,0);
        step();
        drive(0, 0,0,0,0, 0,0,0,0);
        step();
        drive(0, 1,0,0,0, 1,0,1,0);
        step();
        check("fixed conflict ack0", WIDTH'(ack0), 1);
        check("fixed conflict ack1", WIDTH'(ack1), 0);
        drive(0, 0,0,0,0, 1,0,1,0);
        step();
        check("fixed release ack1", WIDTH'(ack1), 1);
        drive(0, 0,0,0,0, 0,0,0,0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // No cycle may ever carry both acks.
    always @(negedge clk) begin
        if (reset === 1'b0 && ack0 === 1'b1 && ack1 === 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dual ack: ack0=%0b ack1=%0b, required not both 1", ack0, ack1);
        end
    end

endmodule : tb_array_port_arbiter
